// File: rtl/ft_tx_arbiter.sv
// rtl/ft_tx_arbiter.sv - round-robin framed-burst arbiter for the FT600 host-bound write path
module ft_tx_arbiter #(
    parameter int DATA_WIDTH  = 24,
    parameter int IQ_BURST    = 512,
    parameter int CTL_MAX_LEN = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] iq_data,
    input  logic                  iq_valid,
    output logic                  iq_ready,
    input  logic [CNT_WIDTH-1:0]  iq_count,
    input  logic [DATA_WIDTH-1:0] ctl_data,
    input  logic                  ctl_valid,
    input  logic                  ctl_last,
    input  logic [11:0]           ctl_len,
    output logic                  ctl_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  err_len,
    output logic [CNT_WIDTH-1:0]  iq_bursts
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HDR     = 3'd1,
        S_IQ_PAY  = 3'd2,
        S_CTL_PAY = 3'd3,
        S_PAD     = 3'd4,
        S_DROP    = 3'd5
    } state_t;

    localparam logic [11:0]          LP_IQ_LEN  = 12'(IQ_BURST);
    localparam logic [11:0]          LP_CTL_MAX = 12'(CTL_MAX_LEN);
    localparam logic [CNT_WIDTH-1:0] LP_IQ_THR  = CNT_WIDTH'(IQ_BURST);

    state_t                r_state;
    state_t                w_next_state;
    logic                  r_last_ctl;     // 1 = control source won the last grant
    logic                  r_src_ctl;      // source of the burst in flight
    logic [11:0]           r_len;
    logic [11:0]           r_wcnt;
    logic [CNT_WIDTH-1:0]  r_iq_bursts;
    logic                  r_err_len;

    logic                  w_iq_elig;
    logic                  w_ctl_elig;
    logic                  w_bad_len;
    logic                  w_wcnt_term;
    logic [23:0]           w_hdr;
    logic                  w_load_iq;
    logic                  w_load_ctl;
    logic                  w_wcnt_clr;
    logic                  w_wcnt_inc;
    logic                  w_burst_done;
    logic                  w_err;

    assign w_iq_elig   = enable & (iq_count >= LP_IQ_THR);
    assign w_ctl_elig  = enable & ctl_valid;
    assign w_bad_len   = (ctl_len == 12'd0) || (ctl_len > LP_CTL_MAX);
    assign w_wcnt_term = (r_wcnt == (r_len - 12'd1));
    assign w_hdr       = {8'hA5, (r_src_ctl ? 4'h2 : 4'h1), r_len};

    assign busy      = (r_state != S_IDLE);
    assign err_len   = r_err_len;
    assign iq_bursts = r_iq_bursts;

    // State register; reset abandons any burst in progress
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state, output muxing and source handshakes
    always_comb begin
        w_next_state = r_state;
        out_valid    = 1'b0;
        out_data     = '0;
        iq_ready     = 1'b0;
        ctl_ready    = 1'b0;
        w_load_iq    = 1'b0;
        w_load_ctl   = 1'b0;
        w_wcnt_clr   = 1'b0;
        w_wcnt_inc   = 1'b0;
        w_burst_done = 1'b0;
        w_err        = 1'b0;
        case (r_state)
            S_IDLE: begin
                // IQ wins a tie only if control had the previous grant
                if (w_iq_elig && (!w_ctl_elig || r_last_ctl)) begin
                    w_load_iq    = 1'b1;
                    w_next_state = S_HDR;
                end else if (w_ctl_elig) begin
                    if (w_bad_len) begin
                        w_err        = 1'b1;
                        w_next_state = S_DROP;
                    end else begin
                        w_load_ctl   = 1'b1;
                        w_next_state = S_HDR;
                    end
                end
            end
            S_HDR: begin
                out_valid = 1'b1;
                out_data  = DATA_WIDTH'(w_hdr);
                if (out_ready) begin
                    w_wcnt_clr   = 1'b1;
                    w_next_state = r_src_ctl ? S_CTL_PAY : S_IQ_PAY;
                end
            end
            S_IQ_PAY: begin
                out_valid = iq_valid;
                out_data  = iq_data;
                iq_ready  = out_ready;
                if (iq_valid && out_ready) begin
                    w_wcnt_inc = 1'b1;
                    if (w_wcnt_term) begin
                        w_burst_done = 1'b1;
                        w_next_state = S_IDLE;
                    end
                end
            end
            S_CTL_PAY: begin
                out_valid = ctl_valid;
                out_data  = ctl_data;
                ctl_ready = out_ready;
                if (ctl_valid && out_ready) begin
                    w_wcnt_inc = 1'b1;
                    if (w_wcnt_term) begin
                        // Clean end takes priority when last and terminal coincide
                        if (ctl_last) begin
                            w_next_state = S_IDLE;
                        end else begin
                            w_err        = 1'b1;
                            w_next_state = S_DROP;
                        end
                    end else if (ctl_last) begin
                        w_next_state = S_PAD;
                    end
                end
            end
            S_PAD: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_wcnt_inc = 1'b1;
                    if (w_wcnt_term) begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            S_DROP: begin
                // Drain the rest of the packet without producing output
                ctl_ready = 1'b1;
                if (ctl_valid && ctl_last) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Burst bookkeeping: grant history, length, word counter, statistics
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_ctl  <= 1'b1;
            r_src_ctl   <= 1'b0;
            r_len       <= '0;
            r_wcnt      <= '0;
            r_iq_bursts <= '0;
            r_err_len   <= 1'b0;
        end else begin
            r_err_len <= w_err;
            if (w_load_iq) begin
                r_len      <= LP_IQ_LEN;
                r_src_ctl  <= 1'b0;
                r_last_ctl <= 1'b0;
            end else if (w_load_ctl) begin
                r_len      <= ctl_len;
                r_src_ctl  <= 1'b1;
                r_last_ctl <= 1'b1;
            end
            if (w_wcnt_clr) begin
                r_wcnt <= '0;
            end else if (w_wcnt_inc) begin
                r_wcnt <= r_wcnt + 12'd1;
            end
            if (w_burst_done) begin
                r_iq_bursts <= r_iq_bursts + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_ft_tx_arbiter.sv
// tb/tb_ft_tx_arbiter.sv - scoreboard bench for ft_tx_arbiter
module tb_ft_tx_arbiter;

    localparam int DW   = 24;
    localparam int IQB  = 512;
    localparam int CMAX = 16;
    localparam int CW   = 16;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          enable = 1'b0;
    logic [DW-1:0] iq_data;
    logic          iq_valid;
    logic          iq_ready;
    logic [CW-1:0] iq_count;
    logic [DW-1:0] ctl_data;
    logic          ctl_valid;
    logic          ctl_last;
    logic [11:0]   ctl_len;
    logic          ctl_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          busy;
    logic          err_len;
    logic [CW-1:0] iq_bursts;

    always #5 clk = ~clk;

    ft_tx_arbiter #(
        .DATA_WIDTH (DW),
        .IQ_BURST   (IQB),
        .CTL_MAX_LEN(CMAX),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .iq_data  (iq_data),
        .iq_valid (iq_valid),
        .iq_ready (iq_ready),
        .iq_count (iq_count),
        .ctl_data (ctl_data),
        .ctl_valid(ctl_valid),
        .ctl_last (ctl_last),
        .ctl_len  (ctl_len),
        .ctl_ready(ctl_ready),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .busy     (busy),
        .err_len  (err_len),
        .iq_bursts(iq_bursts)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        logic [11:0]   len;
    } cword_t;

    cword_t        cq[$];
    logic [DW-1:0] exp_q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            n_err_seen = 0;
    int            n_out = 0;
    int            or_mode = 0;
    logic [DW-1:0] iq_seq = '0;
    logic [DW-1:0] exp_iq_next = '0;
    logic          p_stall = 1'b0;
    logic [DW-1:0] p_data = '0;
    logic          s_busy = 1'b0;
    logic          s_valid = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        iq_data  = iq_seq;
        iq_valid = 1'b1;
        if (cq.size() > 0) begin
            ctl_valid = 1'b1;
            ctl_data  = cq[0].data;
            ctl_last  = cq[0].last;
            ctl_len   = cq[0].len;
        end else begin
            ctl_valid = 1'b0;
            ctl_data  = '0;
            ctl_last  = 1'b0;
            ctl_len   = '0;
        end
        case (or_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic step();
        logic iq_f;
        logic ctl_f;
        @(negedge clk);
        s_busy  = busy;
        s_valid = out_valid;
        if (p_stall) begin
            check_val("hold_valid", 32'(out_valid), 32'd1);
            check_val("hold_data", 32'(out_data), 32'(p_data));
        end
        if (!out_ready) check_val("iq_ready_stall", 32'(iq_ready), 32'd0);
        if (err_len) n_err_seen++;
        if (out_valid && out_ready) begin
            n_out++;
            if (exp_q.size() == 0) check_val("extra_word", 32'(exp_q.size()), 32'd1);
            else check_val("out_word", 32'(out_data), 32'(exp_q.pop_front()));
        end
        p_stall = out_valid && !out_ready;
        p_data  = out_data;
        iq_f    = iq_valid & iq_ready;
        ctl_f   = ctl_valid & ctl_ready;
        @(posedge clk);
        #1;
        if (iq_f) iq_seq++;
        if (ctl_f) void'(cq.pop_front());
        drive();
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (exp_q.size() > 0 && k < budget) begin
            step();
            k++;
        end
        if (exp_q.size() > 0) begin
            check_val({tag, "_timeout"}, 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic push_iq();
        exp_q.push_back({8'hA5, 4'h1, 12'(IQB)});
        for (int i = 0; i < IQB; i++) exp_q.push_back(DW'(exp_iq_next + DW'(i)));
        exp_iq_next = DW'(exp_iq_next + DW'(IQB));
    endtask

    task automatic add_ctl(input int len, input int nwords, input int base);
        for (int i = 0; i < nwords; i++)
            cq.push_back('{data: DW'(base + i), last: (i == nwords - 1), len: 12'(len)});
    endtask

    // Expected host view of one control packet; errs = expected err_len pulses
    task automatic exp_ctl(input int len, input int nwords, input int base, output int errs);
        errs = 0;
        if (len == 0 || len > CMAX) begin
            errs = 1;
        end else begin
            exp_q.push_back({8'hA5, 4'h2, 12'(len)});
            for (int i = 0; i < len; i++) exp_q.push_back((i < nwords) ? DW'(base + i) : '0);
            if (nwords > len) errs = 1;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        exp_q.delete();
        cq.delete();
        p_stall = 1'b0;
        exp_iq_next = iq_seq;
        drive();
    endtask

    initial begin
        int e1;
        int e2;
        int base;
        int start;
        int k;
        iq_count  = '0;
        or_mode   = 0;
        out_ready = 1'b1;
        drive();
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_out_valid", 32'(out_valid), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_iq_ready", 32'(iq_ready), 32'd0);
        check_val("rst_ctl_ready", 32'(ctl_ready), 32'd0);
        check_val("rst_err_len", 32'(err_len), 32'd0);
        check_val("rst_bursts", 32'(iq_bursts), 32'd0);
        reset_n = 1'b1;
        exp_iq_next = iq_seq;

        // Back-to-back IQ bursts with a single idle cycle between them
        enable   = 1'b1;
        iq_count = CW'(600);
        push_iq();
        wait_done("t1a", 1500);
        check_val("t1_bursts1", 32'(iq_bursts), 32'd1);
        push_iq();
        step();
        check_val("t1_idle_gap", 32'(s_busy), 32'd0);
        step();
        check_val("t1_next_hdr", 32'(s_valid), 32'd1);
        wait_done("t1b", 1500);
        iq_count = '0;
        check_val("t1_bursts2", 32'(iq_bursts), 32'd2);

        // Round-robin: IQ, CTL, IQ, CTL with both sources pending
        do_reset();
        base = n_err_seen;
        add_ctl(3, 3, 'h100);
        add_ctl(3, 3, 'h200);
        iq_count = CW'(600);
        drive();
        push_iq();
        exp_ctl(3, 3, 'h100, e1);
        push_iq();
        exp_ctl(3, 3, 'h200, e2);
        wait_done("t2", 3000);
        iq_count = '0;
        check_val("t2_bursts", 32'(iq_bursts), 32'd2);
        check_val("t2_err", 32'(n_err_seen - base), 32'(e1 + e2));

        // Back-pressure: toggling then random out_ready
        or_mode  = 1;
        iq_count = CW'(600);
        push_iq();
        wait_done("t3_iq", 3000);
        iq_count = '0;
        or_mode  = 2;
        add_ctl(5, 5, 'h300);
        exp_ctl(5, 5, 'h300, e1);
        drive();
        wait_done("t3_ctl", 300);
        or_mode = 0;

        // Short packet padded, long packet truncated and drained
        base = n_err_seen;
        add_ctl(4, 2, 'h400);
        add_ctl(2, 5, 'h500);
        exp_ctl(4, 2, 'h400, e1);
        exp_ctl(2, 5, 'h500, e2);
        drive();
        wait_done("t4", 200);
        repeat (10) step();
        check_val("t4_cq_empty", 32'(cq.size()), 32'd0);
        check_val("t4_idle", 32'(s_busy), 32'd0);
        check_val("t4_err", 32'(n_err_seen - base), 32'(e1 + e2));

        // Illegal lengths: no header, packet consumed
        base = n_err_seen;
        add_ctl(0, 3, 'h600);
        add_ctl(17, 17, 'h700);
        exp_ctl(0, 3, 'h600, e1);
        exp_ctl(17, 17, 'h700, e2);
        drive();
        repeat (40) step();
        check_val("t5_cq_empty", 32'(cq.size()), 32'd0);
        check_val("t5_idle", 32'(s_busy), 32'd0);
        check_val("t5_err", 32'(n_err_seen - base), 32'(e1 + e2));

        // Asynchronous reset at payload word 100
        iq_count = CW'(600);
        push_iq();
        start = n_out;
        k = 0;
        while (n_out - start < 101 && k < 1000) begin
            step();
            k++;
        end
        check_val("t6_reached_w100", 32'(n_out - start), 32'd101);
        reset_n = 1'b0;
        #1;
        check_val("t6_rst_valid", 32'(out_valid), 32'd0);
        check_val("t6_rst_iq_ready", 32'(iq_ready), 32'd0);
        check_val("t6_rst_ctl_ready", 32'(ctl_ready), 32'd0);
        check_val("t6_rst_busy", 32'(busy), 32'd0);
        check_val("t6_rst_bursts", 32'(iq_bursts), 32'd0);
        do_reset();
        push_iq();
        wait_done("t6_fresh", 1500);
        check_val("t6_bursts1", 32'(iq_bursts), 32'd1);

        // enable dropped mid-burst: burst completes, no new grant
        push_iq();
        start = n_out;
        k = 0;
        while (n_out - start < 50 && k < 1000) begin
            step();
            k++;
        end
        enable = 1'b0;
        wait_done("t6_en", 1500);
        repeat (20) step();
        check_val("t6_en_idle", 32'(s_busy), 32'd0);
        check_val("t6_en_bursts", 32'(iq_bursts), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
